// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: round-robin grant among functional units, registered
// broadcast of the winner's tag/value, and a saturating grant counter.
module cdb_arbiter #(
    parameter int NUM_UNITS = 4,
    parameter int TAG_W     = 4
) (
    input  logic                       clk,
    input  logic                       RST,
    input  logic                       stall,
    input  logic [NUM_UNITS-1:0]       req,
    input  logic [NUM_UNITS*32-1:0]    data,
    input  logic [NUM_UNITS*TAG_W-1:0] tag,
    output logic [NUM_UNITS-1:0]       ack,
    output logic                       cdb_valid,
    output logic [31:0]                cdb_data,
    output logic [TAG_W-1:0]           cdb_tag,
    output logic [15:0]                grant_count
);
    localparam int PTR_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

    logic [PTR_W-1:0] r_ptr;
    logic             r_cdbValid;
    logic [31:0]      r_cdbData;
    logic [TAG_W-1:0] r_cdbTag;
    logic [15:0]      r_grantCount;

    logic [PTR_W-1:0] w_idx;
    logic [PTR_W-1:0] w_winner;
    logic             w_found;
    logic             w_grant;
    logic [PTR_W-1:0] w_nextPtr;
    logic [31:0]      w_selData;
    logic [TAG_W-1:0] w_selTag;

    // Search upward from the pointer with wrap; first requester found wins.
    always_comb begin
        w_idx    = '0;
        w_winner = '0;
        w_found  = 1'b0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            w_idx = PTR_W'((int'(r_ptr) + k) % NUM_UNITS);
            if (!w_found && req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    assign w_grant   = w_found && !stall && !RST;
    assign w_nextPtr = (w_winner == PTR_W'(NUM_UNITS - 1)) ? '0 : w_winner + PTR_W'(1);

    always_comb begin
        ack       = '0;
        w_selData = '0;
        w_selTag  = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (w_winner == PTR_W'(i)) begin
                ack[i]    = w_grant;
                w_selData = data[i*32 +: 32];
                w_selTag  = tag[i*TAG_W +: TAG_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            r_ptr        <= '0;
            r_cdbValid   <= 1'b0;
            r_cdbData    <= '0;
            r_cdbTag     <= '0;
            r_grantCount <= '0;
        end else if (w_grant) begin
            r_ptr      <= w_nextPtr;
            r_cdbValid <= 1'b1;
            r_cdbData  <= w_selData;
            r_cdbTag   <= w_selTag;
            if (r_grantCount != 16'hFFFF) begin
                r_grantCount <= r_grantCount + 16'd1;
            end
        end else begin
            // Without a grant the bus goes invalid but keeps its last payload.
            r_cdbValid <= 1'b0;
        end
    end

    assign cdb_valid   = r_cdbValid;
    assign cdb_data    = r_cdbData;
    assign cdb_tag     = r_cdbTag;
    assign grant_count = r_grantCount;

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Common Data Bus arbiter and broadcaster for the Tomasulo core. It takes result-bus requests from the functional units, which raise `requireCDB` and wait for `resultAC`. Each cycle it grants at most one request using round-robin priority and acknowledges the winner in the same cycle. On the next clock edge it drives the winning tag and value onto the registered CDB, which the reservation stations and register status table snoop.

## Interface
Parameters:
- `NUM_UNITS`, default 4: number of requesting functional units (2–8).
- `TAG_W`, default 4: width of the reservation-station tag.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `RST`  in  1  reset; synchronous, active-high.
- `stall`  in  1  bus consumers not ready; no grant is issued while high.
- `req`  in  NUM_UNITS  bit i is unit i's `requireCDB`.
- `data`  in  NUM_UNITS*32  unit i's result at bits [32i+31:32i].
- `tag`  in  NUM_UNITS*TAG_W  unit i's tag at bits [TAG_W*i+TAG_W-1:TAG_W*i].
- `ack`  out  NUM_UNITS  one-hot grant; bit i is unit i's `resultAC`.
- `cdb_valid`  out  1  broadcast valid.
- `cdb_data`  out  32  broadcast value.
- `cdb_tag`  out  TAG_W  broadcast tag.
- `grant_count`  out  16  number of grants since reset; saturates at 16'hFFFF.

## Operation
- State: round-robin pointer `ptr` (index of the highest-priority unit), output registers, grant counter.
- Arbitration is combinational. Search starts at `ptr`, moves upward and wraps from NUM_UNITS-1 to 0. The first unit with `req` high wins.
- `ack` = one-hot of the winner when any `req` is high and `stall`=0; otherwise `ack` = 0.
- `ack` depends only on `req`, `stall` and `ptr`. It must not depend on `data` or `tag`.
- On a rising edge with a grant to unit w:
  - `cdb_valid`<=1, `cdb_data`<=data[w], `cdb_tag`<=tag[w].
  - `ptr`<=(w+1) mod NUM_UNITS.
  - `grant_count`<=`grant_count`+1, unless already 16'hFFFF.
- On a rising edge with no grant (no `req`, or `stall`=1):
  - `cdb_valid`<=0.
  - `cdb_data` and `cdb_tag` hold their previous values.
  - `ptr` holds.
- Requester contract: a unit holds `req`, `data` and `tag` stable until it sees `ack` high at a rising edge. It may raise `req` again in the very next cycle with a new result.
- An unacknowledged request is never dropped by the arbiter. With round-robin, any continuously asserted request is granted within NUM_UNITS non-stalled cycles.

## Timing
- Reset: when `RST`=1 at a rising edge:
  - `cdb_valid`=0, `cdb_data`=0, `cdb_tag`=0, `ptr`=0, `grant_count`=0.
  - `ack` is forced to 0 for the whole cycle in which `RST` is high.
- Reset mid-operation: a grant that coincides with `RST` is discarded. The requester sees `ack`=0 and keeps requesting.
- Latency:
  - `ack` appears in the same cycle as `req` (0 cycles).
  - The broadcast is visible one cycle after the ack cycle and lasts exactly one cycle unless another grant follows.
- Throughput: one broadcast per cycle. The same unit may win on consecutive cycles when it is the only requester.
- Stall: while `stall`=1, `ack`=0 and `cdb_valid` is 0 from the next cycle. The broadcast already on the bus in the stall cycle is not affected.
- Pointer wrap: a grant to unit NUM_UNITS-1 sets `ptr`=0.
- Simultaneous requests: exactly one `ack` bit is high. The losers see `ack`=0 and retry.

## Test plan
- Reset, then unit 2 requests with data 0x0000_00AA and tag 5, `stall`=0:
  - `ack`=4'b0100 in the same cycle.
  - Next cycle `cdb_valid`=1, `cdb_data`=0x0000_00AA, `cdb_tag`=5.
  - `grant_count`=1.
- All four units request continuously with `ptr`=0:
  - Grants go to 0, 1, 2, 3, 0 on five consecutive cycles.
  - Broadcast tags follow the same order, one cycle later.
- Unit 1 and unit 3 request, `stall`=1 for 3 cycles, then `stall`=0:
  - `ack`=0 and `cdb_valid`=0 during the stall.
  - The first grant after the stall goes to unit 1, then unit 3.
- Unit 0 is the only requester for 4 cycles, changing data each cycle after `ack`:
  - 4 back-to-back broadcasts carrying the 4 values.
  - `cdb_valid` stays high for all 4 cycles.
- `RST` is asserted in the cycle unit 2 is granted:
  - `ack`=0.
  - Next cycle all outputs are 0 and `ptr`=0.
  - Unit 2's held request is then granted.
- Force `grant_count` to 16'hFFFE, then apply 3 grants: the count saturates at 16'hFFFF.
